piso_serializer_8b: RTL and testbench

Parallel-in/serial-out transmitter for the 8-bit serial display path. It accepts a parallel word through a ready/load handshake and shifts it out one bit per bit period, MSB- or LSB-first. Each bit comes with a one-cycle sample strobe, and a one-cycle latch pulse ends the frame. It drives the bidirectional serial-in shift-register receiver, so a frame sent with a given `side` lands in the receiver in the original bit order.

---
 rtl/piso_serializer_8b.sv | 136 +++++++++++++
 tb/tb_piso_serializer_8b.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/piso_serializer_8b.sv
// piso_serializer_8b
//   Parallel-in/serial-out transmitter for the serial display path. A word is
//   accepted on load && ready and shifted out MSB- or LSB-first. Each bit is
//   held BIT_DIV cycles, with a one-cycle shift_strobe in the last cycle of each
//   bit period. A one-cycle latch pulse closes the frame.
//
//   Build option: define PISO_INVERT_EN to transmit ~data. This pairs with a
//   receiver whose parallel output is inverted.
//
// Parameters
//   WIDTH    bits per frame (>=2)
//   BIT_DIV  clock cycles per serial bit (>=1)
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-low reset
//   side          1 = MSB-first, 0 = LSB-first (sampled at acceptance)
//   data          parallel word (sampled at acceptance)
//   load          transmit request
//   ready         high in IDLE
//   sdata         serial data
//   shift_strobe  receiver sample strobe, last cycle of each bit period
//   latch         one-cycle end-of-frame pulse
//   busy          ~ready
module piso_serializer_8b #(
  parameter int WIDTH   = 8,
  parameter int BIT_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             side,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  output logic             ready,
  output logic             sdata,
  output logic             shift_strobe,
  output logic             latch,
  output logic             busy
);

  localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  // With one cycle per bit every cycle of SHIFT is a strobe cycle.
  localparam logic ONE_CYC = (BIT_DIV == 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic             side_q;
  logic [BW-1:0]    bit_cnt;
  logic [DW-1:0]    div_cnt;

  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] sreg_nxt;
  logic [DW-1:0]    div_inc;

`ifdef PISO_INVERT_EN
  assign cap = ~data;
`else
  assign cap = data;
`endif

  // Shift toward the output end: MSB end for MSB-first, LSB end otherwise.
  assign sreg_nxt = side_q ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
  assign div_inc  = div_cnt + DW'(1);
  assign busy     = ~ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      ready        <= 1'b1;
      sdata        <= 1'b0;
      shift_strobe <= 1'b0;
      latch        <= 1'b0;
      sreg         <= '0;
      side_q       <= 1'b0;
      bit_cnt      <= '0;
      div_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready        <= 1'b1;
          shift_strobe <= 1'b0;
          latch        <= 1'b0;
          sdata        <= 1'b0;
          if (load && ready) begin
            state        <= SHIFT;
            ready        <= 1'b0;
            sreg         <= cap;
            side_q       <= side;
            // First bit goes out in the same update as the capture.
            sdata        <= side ? cap[WIDTH-1] : cap[0];
            shift_strobe <= ONE_CYC;
            bit_cnt      <= '0;
            div_cnt      <= '0;
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            if (bit_cnt == BIT_LAST) begin
              state        <= LATCH;
              latch        <= 1'b1;
              sdata        <= 1'b0;
              shift_strobe <= 1'b0;
              div_cnt      <= '0;
            end else begin
              sreg         <= sreg_nxt;
              sdata        <= side_q ? sreg_nxt[WIDTH-1] : sreg_nxt[0];
              bit_cnt      <= bit_cnt + BW'(1);
              div_cnt      <= '0;
              shift_strobe <= ONE_CYC;
            end
          end else begin
            div_cnt      <= div_inc;
            shift_strobe <= (div_inc == DIV_LAST);
          end
        end
        LATCH: begin
          state        <= IDLE;
          latch        <= 1'b0;
          ready        <= 1'b1;
          sdata        <= 1'b0;
          shift_strobe <= 1'b0;
          bit_cnt      <= '0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer_8b.sv
module tb_piso_serializer_8b;

`ifdef PISO_INVERT_EN
  localparam logic [7:0] INV = 8'hFF;
`else
  localparam logic [7:0] INV = 8'h00;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, side, load, sel;
  logic [7:0] data;
  logic       rdy1, sd1, st1, la1, bz1;
  logic       rdy3, sd3, st3, la3, bz3;
  logic       rdy, sd, st, la, bz;
  logic       ld1, ld3;
  int         vecs = 0;
  int         errs = 0;

  assign ld1 = load & ~sel;
  assign ld3 = load & sel;
  assign rdy = sel ? rdy3 : rdy1;
  assign sd  = sel ? sd3  : sd1;
  assign st  = sel ? st3  : st1;
  assign la  = sel ? la3  : la1;
  assign bz  = sel ? bz3  : bz1;

  piso_serializer_8b #(.WIDTH(8), .BIT_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .side(side), .data(data), .load(ld1),
    .ready(rdy1), .sdata(sd1), .shift_strobe(st1), .latch(la1), .busy(bz1));

  piso_serializer_8b #(.WIDTH(8), .BIT_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .side(side), .data(data), .load(ld3),
    .ready(rdy3), .sdata(sd3), .shift_strobe(st3), .latch(la3), .busy(bz3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, rdy, 1);
    chk({tag, "_sdata"}, sd, 0);
    chk({tag, "_strobe"}, st, 0);
    chk({tag, "_latch"}, la, 0);
  endtask

  // One frame on the selected DUT. Expected waveform is derived from the
  // bit period rule: cycle j after acceptance carries bit j/BD, strobe when
  // j%BD==BD-1, latch at j==8*BD. A receiver model rebuilds the word.
  task automatic run_frame(input logic [7:0] d, input logic s, input int pulse_at,
                           input logic hold, input logic [7:0] nd, input logic ns,
                           input int abort_at);
    int n, bd, nstb;
    logic [7:0] tx, rx;
    logic eb;
    bd = sel ? 3 : 1;
    tx = d ^ INV;
    n = 0;
    while (!rdy && n < 200) begin @(negedge clk); n++; end
    chk("ready_wait", rdy, 1);
    load = 1'b1; data = d; side = s;
    @(posedge clk); #1;
    if (hold) begin data = nd; side = ns; end
    else begin load = 1'b0; data = 8'($urandom); side = 1'($urandom); end
    rx = '0; nstb = 0;
    for (int j = 0; j <= 8*bd; j++) begin
      @(negedge clk);
      if (!hold) load = (j == pulse_at);
      if (j == pulse_at) data = 8'hFF;
      chk("ready_low", rdy, 0);
      chk("busy", bz, 1);
      if (j < 8*bd) begin
        eb = s ? tx[7 - j/bd] : tx[j/bd];
        chk("sdata", sd, eb);
        chk("strobe", st, ((j % bd) == bd - 1));
        chk("latch_idle", la, 0);
        if (st) begin
          rx = s ? {rx[6:0], sd} : {sd, rx[7:1]};
          nstb++;
          if (nstb == abort_at) begin
            rst = 1'b0; load = 1'b0;
            @(negedge clk);
            chk_idle("abort");
            chk("abort_busy", bz, 0);
            rst = 1'b1;
            repeat (8*bd) begin
              @(negedge clk);
              chk("abort_nolatch", la, 0);
            end
            return;
          end
        end
      end else begin
        chk("latch", la, 1);
        chk("sdata_latch", sd, 0);
        chk("strobe_latch", st, 0);
        chk("nstrobes", nstb, 8);
        chk("rx_word", rx ^ INV, d);
      end
    end
    @(negedge clk);
    chk("ready_back", rdy, 1);
  endtask

  initial begin
    rst = 1'b0; load = 1'b1; sel = 1'b0; data = 8'hA5; side = 1'b1;
    // Reset held with load asserted: nothing may be accepted.
    repeat (3) begin
      @(negedge clk);
      chk_idle("reset");
      chk("reset_busy", bz, 0);
      chk("reset_ready3", rdy3, 1);
    end
    load = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");

    sel = 1'b0; run_frame(8'hC4, 1'b1, -1, 1'b0, 8'h00, 1'b0, -1);
    sel = 1'b1; run_frame(8'hC4, 1'b0, -1, 1'b0, 8'h00, 1'b0, -1);

    // load pulsed while busy is ignored.
    sel = 1'b0; run_frame(8'h96, 1'b1, 3, 1'b0, 8'h00, 1'b0, -1);
    sel = 1'b1; run_frame(8'h3C, 1'b0, 7, 1'b0, 8'h00, 1'b0, -1);

    // Streaming with load held high.
    sel = 1'b0; run_frame(8'h01, 1'b1, -1, 1'b1, 8'h80, 1'b0, -1);
    run_frame(8'h80, 1'b0, -1, 1'b0, 8'h00, 1'b0, -1);
    sel = 1'b1; run_frame(8'h01, 1'b0, -1, 1'b1, 8'h80, 1'b1, -1);
    run_frame(8'h80, 1'b1, -1, 1'b0, 8'h00, 1'b0, -1);

    // Reset after the 4th strobe, then a clean frame.
    sel = 1'b0; run_frame(8'h33, 1'b1, -1, 1'b0, 8'h00, 1'b0, 4);
    run_frame(8'h5A, 1'b1, -1, 1'b0, 8'h00, 1'b0, -1);
    sel = 1'b1; run_frame(8'hE7, 1'b0, -1, 1'b0, 8'h00, 1'b0, 4);
    run_frame(8'h5A, 1'b0, -1, 1'b0, 8'h00, 1'b0, -1);

    // Random words, both orders, both rates.
    for (int i = 0; i < 12; i++) begin
      sel = 1'($urandom);
      run_frame(8'($urandom), 1'($urandom), -1, 1'b0, 8'h00, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
